// File: rtl/dotprod_stream_ctrl.sv
// dotprod_stream_ctrl: stream-to-vector front end for the dotprod core.
//
// Collects (a,b) element pairs from a valid/ready input stream into an
// N-element vector bank, zero-pads short vectors, starts the core and
// returns the captured result with its element count on a valid/ready
// output stream. There is a single bank, so filling and computing never
// overlap.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   input pair handshake
//   in_a, in_b       element pair, two's complement (not interpreted here)
//   in_last          marks the final pair of the current vector
//   dp_a, dp_b       packed vectors to the core, element i at [i*IN_WIDTH +: IN_WIDTH]
//   dp_start         core start, held high until the core reports done
//   dp_done          core done
//   dp_result        core result
//   out_valid/ready  result handshake
//   out_result       captured dot product
//   out_count        number of real (non-padded) elements in the vector
module dotprod_stream_ctrl #(
    parameter int unsigned N         = 8,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 64,
    localparam int unsigned CNT_W    = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     in_a,
    input  logic [IN_WIDTH-1:0]     in_b,
    input  logic                    in_last,

    output logic [N*IN_WIDTH-1:0]   dp_a,
    output logic [N*IN_WIDTH-1:0]   dp_b,
    output logic                    dp_start,
    input  logic                    dp_done,
    input  logic [OUT_WIDTH-1:0]    dp_result,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_result,
    output logic [CNT_W-1:0]        out_count
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             close_vec;

    // in_ready is a register that mirrors (state == FILL), so accept is
    // only ever true in FILL.
    assign accept    = in_valid & in_ready;

    // A vector closes on in_last or when the Nth element is accepted.
    assign close_vec = accept & (in_last | (cnt == CNT_W'(N - 1)));

    // Controller state, vector bank and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            in_ready   <= 1'b1;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_start   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_count  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        // Write slot cnt; on close, clear every slot above it
                        // so stale data from an earlier vector never reaches
                        // the core.
                        for (int unsigned i = 0; i < N; i++) begin
                            if (CNT_W'(i) == cnt) begin
                                dp_a[i*IN_WIDTH +: IN_WIDTH] <= in_a;
                                dp_b[i*IN_WIDTH +: IN_WIDTH] <= in_b;
                            end else if (close_vec && (CNT_W'(i) > cnt)) begin
                                dp_a[i*IN_WIDTH +: IN_WIDTH] <= '0;
                                dp_b[i*IN_WIDTH +: IN_WIDTH] <= '0;
                            end
                        end

                        if (close_vec) begin
                            out_count <= cnt + CNT_W'(1);
                            cnt       <= '0;
                            dp_start  <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= RUN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                RUN: begin
                    // Bank stays frozen: the core samples it one cycle
                    // after start and start is held until done.
                    if (dp_done) begin
                        out_result <= dp_result;
                        dp_start   <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end

                OUT: begin
                    // At least one cycle with start low here lets the core
                    // fall back to idle before the next start.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= FILL;
                    end
                end

                default: begin
                    state     <= FILL;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    dp_start  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dotprod_stream_ctrl.md
Name: dotprod_stream_ctrl

Overview:
Upstream/downstream controller that wraps the dotprod core. It collects a valid/ready stream of (a,b) element pairs into an N-element vector bank, zero-pads short vectors, and drives the core's parallel vector inputs and start. It waits for done, captures the result, and returns it on a valid/ready output stream together with the element count.

Parameters:
N, 8, elements per vector (must match core N)
IN_WIDTH, 32, element width, two's complement
OUT_WIDTH, 64, result width (must match core OUT_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  element pair valid
in_ready  out  1  controller accepts pair this cycle
in_a  in  IN_WIDTH  element of vector A
in_b  in  IN_WIDTH  element of vector B
in_last  in  1  final pair of current vector
dp_a  out  N*IN_WIDTH  vector A to core; element i at bits [i*IN_WIDTH +: IN_WIDTH], maps to core a0..a7
dp_b  out  N*IN_WIDTH  vector B to core, same packing
dp_start  out  1  core start, registered
dp_done  in  1  core done
dp_result  in  OUT_WIDTH  core result
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  OUT_WIDTH  captured dot product
out_count  out  $clog2(N+1)  number of real (non-padded) elements in vector

Behaviour:
- Reset (async, rst_n=0): state FILL, cnt=0, dp_a=dp_b=0, dp_start=0, out_valid=0, out_result=0, out_count=0. in_ready=1 after reset because in_ready = (state==FILL).
- Accept = in_valid & in_ready. On accept, write element cnt of the bank and increment cnt.
- FILL: on accept with in_last=1 or cnt==N-1, close the vector:
  - Elements cnt+1..N-1 are cleared to 0 in the same edge (zero-pad).
  - out_count <= cnt+1; cnt <= 0; dp_start <= 1; go to RUN.
  - A vector holds 1..N elements; in_last on the Nth element is redundant, not an error.
  - If in_last is absent, the vector closes at N elements and the next accepted pair starts a new vector.
- RUN: in_ready=0, dp_start held 1. dp_a/dp_b are frozen, because the core samples them one cycle after start, in its LOAD state. Wait for dp_done=1; on that edge, out_result <= dp_result, dp_start <= 0, out_valid <= 1; go to OUT. No timeout.
- OUT: in_ready=0, dp_start=0, out_valid held until out_ready=1. On handshake: out_valid <= 0, go to FILL.
  - OUT lasts at least one cycle with dp_start=0, so the core returns to IDLE before the next start. This guarantee is required.
- out_result and out_count hold their values until the next capture.
- Latency, full vector with in_valid held high: last accept -> dp_start high next cycle -> core needs 1 (LOAD) + N (CALC) cycles -> done. out_valid rises N+3 cycles after the last accept, given the core timing.
- Back-to-back: in_ready returns on the cycle after the out handshake. No overlap of fill and compute (single bank).
- in_a/in_b/in_last are ignored when in_valid=0, and in all non-FILL states.
- Reset mid-operation (any state): immediate return to reset values. The partial vector is discarded. The core is reset by its own reset; integration ties rst = ~rst_n.
- Arithmetic: none in this block. Signed interpretation is the core's.

Test Plan:
- Full vector a=1..8, b=1..8 streamed one per cycle, in_last on 8th, out_ready=1 -> out_valid once, out_result=204, out_count=8; dp_start high exactly from the cycle after the last accept until done is seen.
- Short vector a={2,3,4}, b={5,6,7}, in_last on 3rd -> dp_a elements 3..7 = 0, out_result=56, out_count=3.
- Signed: a=-3 (0xFFFFFFFD) in all 8 slots, b=2 in all slots -> out_result = -48 (0xFFFF_FFFF_FFFF_FFD0).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_result stable, in_ready=0, dp_start=0 throughout; release -> in_ready=1 next cycle.
- Back-to-back vectors, in_valid held high, 16 pairs without in_last (values 1..16 for both) -> two results, 204 and 1292, each with out_count=8, in order.
- Reset: assert rst_n=0 during RUN and again after 4 accepts in FILL -> all outputs at reset values, in_ready=1; next full vector produces a correct result.
